// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: sequences fixed-latency MULT/DIV operations with a
// down-counter, owns the architectural HI/LO registers and raises a D-stage stall request.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [3:0]  cnt;
    logic [31:0] hi_tmp;
    logic [31:0] lo_tmp;
    logic        div_zero;

    logic               accept;
    logic               is_muldiv;
    logic               rt_zero;
    logic               div_ovf;
    logic [31:0]        rt_safe;
    logic signed [63:0] rs_sext;
    logic signed [63:0] rt_sext;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    // Handshake: an op is taken when start is high, busy is low and op is
    // 1..6; start while busy is dropped, the stall unit keeps that from happening.
    assign busy      = (cnt != 4'd0);
    assign accept    = start & ~busy & (op != 3'd0) & (op != 3'd7);
    assign is_muldiv = (op >= OP_MULT) && (op <= OP_DIVU);
    assign md_stall  = md_D & (busy | (start & is_muldiv));

    assign rs_sext = {{32{rs_val[31]}}, rs_val};
    assign rt_sext = {{32{rt_val[31]}}, rt_val};
    assign prod_s  = rs_sext * rt_sext;
    assign prod_u  = {32'd0, rs_val} * {32'd0, rt_val};

    // Divisor forced to 1 on zero so the datapath stays defined; the commit is suppressed instead.
    assign rt_zero = (rt_val == 32'd0);
    assign rt_safe = rt_zero ? 32'd1 : rt_val;
    assign div_ovf = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

    always_comb begin
        quot_s = 32'd0;
        rem_s  = 32'd0;
        if (div_ovf) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
        end else begin
            quot_s = $signed(rs_val) / $signed(rt_safe);
            rem_s  = $signed(rs_val) % $signed(rt_safe);
        end
    end

    assign quot_u = rs_val / rt_safe;
    assign rem_u  = rs_val % rt_safe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= 4'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            hi_tmp   <= 32'd0;
            lo_tmp   <= 32'd0;
            div_zero <= 1'b0;
        end else if (busy) begin
            if (cnt == 4'd1) begin
                cnt <= 4'd0;
                if (!div_zero) begin
                    hi <= hi_tmp;
                    lo <= lo_tmp;
                end
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else if (accept) begin
            case (op)
                OP_MULT: begin
                    {hi_tmp, lo_tmp} <= prod_s;
                    div_zero         <= 1'b0;
                    cnt              <= 4'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    {hi_tmp, lo_tmp} <= prod_u;
                    div_zero         <= 1'b0;
                    cnt              <= 4'(MULT_CYCLES);
                end
                OP_DIV: begin
                    lo_tmp   <= quot_s;
                    hi_tmp   <= rem_s;
                    div_zero <= rt_zero;
                    cnt      <= 4'(DIV_CYCLES);
                end
                OP_DIVU: begin
                    lo_tmp   <= quot_u;
                    hi_tmp   <= rem_u;
                    div_zero <= rt_zero;
                    cnt      <= 4'(DIV_CYCLES);
                end
                OP_MTHI: hi <= rs_val;
                OP_MTLO: lo <= rs_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: inputs change on the falling edge, outputs are
// checked on the falling edge (or shortly after an asynchronous event).
module tb_mdu_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_D;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_stall;

    int checks;
    int failures;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .md_D     (md_D),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .md_stall (md_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one op for a single cycle; returns at the falling edge of the next cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        op     = 3'd0;
    endtask

    // Counts falling edges with busy high, bounded so a stuck busy cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        rs_val  = 32'd0;
        rt_val  = 32'd0;
        md_D    = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || md_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset: busy=%b hi=%h lo=%h md_stall=%b expected 0 0 0 0",
                     busy, hi, lo, md_stall);
        end
        md_D = 1'b0;
    endtask

    task automatic test_mult;
        int n;
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL mult_busy_cycles: got %0d expected 5", n);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            failures++;
            $display("FAIL mult_result: hi=%h lo=%h expected ffffffff fffffffa", hi, lo);
        end
        issue(3'd2, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        checks++;
        if (n !== 5 || hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
            failures++;
            $display("FAIL multu_result: cycles=%0d hi=%h lo=%h expected 5 00000002 fffffffa",
                     n, hi, lo);
        end
    endtask

    task automatic test_div;
        int n;
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL div_busy_cycles: got %0d expected 10", n);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL div_result: hi=%h lo=%h expected ffffffff fffffffd", hi, lo);
        end
        issue(3'd4, 32'd7, 32'd2);
        wait_idle(n);
        checks++;
        if (n !== 10 || hi !== 32'd1 || lo !== 32'd3) begin
            failures++;
            $display("FAIL divu_result: cycles=%0d hi=%h lo=%h expected 10 00000001 00000003",
                     n, hi, lo);
        end
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        checks++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            failures++;
            $display("FAIL div_overflow: hi=%h lo=%h expected 00000000 80000000", hi, lo);
        end
    endtask

    task automatic test_mt_div_zero;
        int n;
        issue(3'd5, 32'h11, 32'hDEAD_BEEF);
        checks++;
        if (hi !== 32'h11 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi: hi=%h busy=%b expected 00000011 0", hi, busy);
        end
        issue(3'd6, 32'h22, 32'd0);
        checks++;
        if (lo !== 32'h22 || hi !== 32'h11 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b expected 00000011 00000022 0", hi, lo, busy);
        end
        issue(3'd3, 32'd5, 32'd0);
        wait_idle(n);
        checks++;
        if (n !== 10 || hi !== 32'h11 || lo !== 32'h22) begin
            failures++;
            $display("FAIL div_by_zero: cycles=%0d hi=%h lo=%h expected 10 00000011 00000022",
                     n, hi, lo);
        end
    endtask

    task automatic test_stall_and_ignore;
        int bad;
        bad = 0;
        @(negedge clk);
        md_D   = 1'b1;
        start  = 1'b1;
        op     = 3'd1;
        rs_val = 32'd5;
        rt_val = 32'hFFFF_FFFD;
        #1;
        checks++;
        if (md_stall !== 1'b1) begin
            failures++;
            $display("FAIL stall_start_cycle: md_stall=%b expected 1", md_stall);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        for (int i = 1; i <= 5; i++) begin
            if (md_stall !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL stall_busy_cycle%0d: md_stall=%b busy=%b expected 1 1",
                         i, md_stall, busy);
            end
            if (i == 2) begin
                start  = 1'b1;
                op     = 3'd4;
                rs_val = 32'd7;
                rt_val = 32'd2;
            end else if (i == 3) begin
                start = 1'b0;
                op    = 3'd0;
            end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) failures++;
        checks++;
        if (busy !== 1'b0 || md_stall !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: busy=%b md_stall=%b expected 0 0", busy, md_stall);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            failures++;
            $display("FAIL ignore_start_busy: hi=%h lo=%h expected ffffffff fffffff1", hi, lo);
        end
        md_D = 1'b0;
    endtask

    task automatic test_async_reset;
        int n;
        issue(3'd3, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
        end
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) n++;
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL no_late_commit: %0d bad cycles busy=%b hi=%h lo=%h expected 0",
                     n, busy, hi, lo);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mult();
        test_div();
        test_mt_div_zero();
        test_stall_and_ignore();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
